// File: rtl/dds_cfg_pkg.sv
// Shared types, widths and the elaboration-time reciprocal constant
// for the multi-lane DDS phase configuration master.
package dds_cfg_pkg;

  localparam int DEF_LANES  = 8;
  localparam int LANES_LOG2 = $clog2(DEF_LANES);
  localparam int PHASE_W    = 32;
  localparam int CFG_W      = 64;
  localparam int K_W        = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL1,
    ST_MUL2,
    ST_ISSUE,
    ST_DONE
  } cfg_state_e;

  // K = round(2^(32+frac_bits) / (lanes * clk_hz)); wide math keeps it exact.
  function automatic logic [K_W-1:0] calc_k(input longint unsigned clk_hz,
                                            input int unsigned     lanes,
                                            input int unsigned     frac_bits);
    logic [127:0] fs;
    logic [127:0] num;
    fs  = 128'(clk_hz) * 128'(lanes);
    num = 128'(1) << (PHASE_W + frac_bits);
    return K_W'((num + (fs >> 1)) / fs);
  endfunction

endpackage

// File: rtl/dds_phase_step_mul.sv
// Pipelined frequency-to-phase-step multiply: d = round(frq*K / 2^FRAC_BITS) mod 2^32.
// Fixed two-cycle latency from vld_i to vld_o.
module dds_phase_step_mul
  import dds_cfg_pkg::*;
#(
  parameter int             FRAC_BITS = 32,
  parameter logic [K_W-1:0] K         = calc_k(64'd200000000, 32'd8, 32'd32)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [PHASE_W-1:0] frq_i,
  input  logic               vld_i,
  output logic [PHASE_W-1:0] d_o,
  output logic               vld_o
);

  localparam int                STAGES = 2;
  localparam int                PROD_W = PHASE_W + K_W;
  localparam logic [PROD_W-1:0] RND    = PROD_W'(1) << (FRAC_BITS - 1);

  logic [PROD_W-1:0] prod_q;
  logic [STAGES:1]   vld_pipe;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prod_q   <= '0;
      d_o      <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], vld_i};
      if (vld_i)
        prod_q <= PROD_W'(frq_i) * PROD_W'(K);
      // Round half-up, then keep only the low phase bits (wraps at FS).
      if (vld_pipe[1])
        d_o <= PHASE_W'((prod_q + RND) >> FRAC_BITS);
    end
  end

  assign vld_o = vld_pipe[STAGES];

endmodule

// File: rtl/dds_lane_config_master.sv
// Converts a requested frequency into per-lane {offset, increment} config beats
// and issues them one lane at a time over one-hot AXI-Stream valids.
module dds_lane_config_master
  import dds_cfg_pkg::*;
#(
  parameter int          LANES      = 8,
  parameter int unsigned CLK_FRQ_HZ = 200000000,
  parameter int          FRAC_BITS  = 32
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [31:0]        s_frq_tdata,
  input  logic               s_frq_tvalid,
  output logic               s_frq_tready,
  output logic [63:0]        m_axis_config_tdata,
  output logic [LANES-1:0]   m_axis_config_tvalid,
  input  logic [LANES-1:0]   m_axis_config_tready,
  output logic               busy,
  output logic               cfg_done
);

  localparam int             LG = $clog2(LANES);
  localparam logic [K_W-1:0] K  = calc_k(64'(CLK_FRQ_HZ), 32'(LANES), 32'(FRAC_BITS));

  cfg_state_e         state_q;
  logic [LG-1:0]      lane_q;
  logic [PHASE_W-1:0] d_q;
  logic [PHASE_W-1:0] off_q;
  logic [CFG_W-1:0]   tdata_q;
  logic [LANES-1:0]   tvalid_q;
  logic               tready_q;
  logic               busy_q;
  logic               done_q;

  logic [PHASE_W-1:0] mul_d;
  logic               mul_vld;
  logic               accept;
  logic               hs;
  logic               last;

  // tready_q is only ever high in IDLE, so it alone qualifies the accept.
  assign accept = tready_q & s_frq_tvalid;
  // tvalid_q is one-hot at lane_q, so other lanes' ready bits fall out here.
  assign hs     = |(tvalid_q & m_axis_config_tready);
  assign last   = (lane_q == LG'(LANES - 1));

  dds_phase_step_mul #(
    .FRAC_BITS (FRAC_BITS),
    .K         (K)
  ) u_mul (
    .aclk    (aclk),
    .aresetn (aresetn),
    .frq_i   (s_frq_tdata),
    .vld_i   (accept),
    .d_o     (mul_d),
    .vld_o   (mul_vld)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      lane_q   <= '0;
      d_q      <= '0;
      off_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= '0;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tready_q <= 1'b1;
          if (accept) begin
            tready_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_MUL1;
          end
        end
        ST_MUL1: state_q <= ST_MUL2;
        ST_MUL2: begin
          if (mul_vld) begin
            // Lane 0 offset is zero; off_q already holds lane 1's offset.
            d_q      <= mul_d;
            off_q    <= mul_d;
            lane_q   <= '0;
            tvalid_q <= LANES'(1);
            tdata_q  <= {PHASE_W'(0), mul_d << LG};
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            if (last) begin
              tvalid_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              lane_q         <= lane_q + LG'(1);
              tvalid_q       <= tvalid_q << 1;
              tdata_q[63:32] <= off_q;
              off_q          <= off_q + d_q;
            end
          end
        end
        ST_DONE: begin
          tready_q <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_frq_tready         = tready_q;
  assign m_axis_config_tdata  = tdata_q;
  assign m_axis_config_tvalid = tvalid_q;
  assign busy                 = busy_q;
  assign cfg_done             = done_q;

endmodule

// File: tb/tb_dds_lane_config_master.sv
// Directed + randomized bench for dds_lane_config_master against an
// arithmetic reference model of the lane phase configuration.
module tb_dds_lane_config_master;

  localparam int          LANES = 8;
  localparam logic [63:0] K_REF = 64'd11529215046;

  logic              aclk;
  logic              aresetn;
  logic [31:0]       s_frq_tdata;
  logic              s_frq_tvalid;
  logic              s_frq_tready;
  logic [63:0]       m_tdata;
  logic [LANES-1:0]  m_tvalid;
  logic [LANES-1:0]  m_tready;
  logic              busy;
  logic              cfg_done;

  int nvec  = 0;
  int nfail = 0;

  dds_lane_config_master #(
    .LANES      (LANES),
    .CLK_FRQ_HZ (200000000),
    .FRAC_BITS  (32)
  ) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_frq_tdata          (s_frq_tdata),
    .s_frq_tvalid         (s_frq_tvalid),
    .s_frq_tready         (s_frq_tready),
    .m_axis_config_tdata  (m_tdata),
    .m_axis_config_tvalid (m_tvalid),
    .m_axis_config_tready (m_tready),
    .busy                 (busy),
    .cfg_done             (cfg_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Phase step per sample for FS = 1.6 GHz, rounded, wrapped to 32 bits.
  function automatic logic [31:0] model_d(input logic [31:0] f);
    logic [127:0] p;
    p = 128'(f) * 128'(K_REF);
    return 32'((p + (128'(1) << 31)) >> 32);
  endfunction

  // Runs one request from an IDLE negedge. abort_lane >= 0 returns with that
  // lane pending; hold keeps s_frq_tvalid high with nfrq after the accept.
  task automatic run_cfg(input logic [31:0] frq, input int stall_lane, input int stall_n,
                         input int abort_lane, input bit hold, input logic [31:0] nfrq);
    logic [31:0]      d;
    logic [63:0]      exp_beat [LANES];
    logic [LANES-1:0] r;
    int lane, stall_left, n, first_n, exp_done;
    bit done;
    d = model_d(frq);
    for (int i = 0; i < LANES; i++)
      exp_beat[i] = {32'(i) * d, d * 32'(LANES)};
    exp_done = 3 + LANES + ((stall_lane >= 0) ? stall_n : 0);

    chk("tready_idle", 64'(s_frq_tready), 64'(1));
    s_frq_tvalid = 1'b1;
    s_frq_tdata  = frq;
    @(posedge aclk);
    @(negedge aclk);
    n = 1;
    if (hold) s_frq_tdata = nfrq;
    else      s_frq_tvalid = 1'b0;
    lane = 0; stall_left = stall_n; done = 0; first_n = -1;

    while (!done && n < 100) begin
      if (lane < LANES) begin
        chk("busy", 64'(busy), 64'(1));
        chk("cfg_done_early", 64'(cfg_done), 64'(0));
        chk("tready_busy", 64'(s_frq_tready), 64'(0));
        if (m_tvalid !== '0) begin
          if (first_n < 0) first_n = n;
          chk("tvalid_onehot", 64'(m_tvalid), 64'(1) << lane);
          chk("tdata", m_tdata, exp_beat[lane]);
          if (lane == abort_lane) begin
            m_tready = '0;
            return;
          end
          r = LANES'($urandom);
          if (lane == stall_lane && stall_left > 0) begin
            r[lane] = 1'b0;
            stall_left--;
          end else begin
            r[lane] = 1'b1;
          end
          m_tready = r;
          if (r[lane]) lane++;
        end else begin
          chk("tvalid_gap", 64'(first_n < 0), 64'(1));
          m_tready = LANES'($urandom);
        end
      end else begin
        chk("cfg_done", 64'(cfg_done), 64'(1));
        chk("busy_done", 64'(busy), 64'(0));
        chk("tvalid_done", 64'(m_tvalid), 64'(0));
        chk("done_cycle", 64'(n), 64'(exp_done));
        done = 1;
      end
      if (!done) begin
        @(negedge aclk);
        n++;
      end
    end
    if (!done) chk("timeout", 64'(0), 64'(1));
    chk("first_valid_cycle", 64'(first_n), 64'(3));
    m_tready = '0;
    @(negedge aclk);
    chk("cfg_done_pulse", 64'(cfg_done), 64'(0));
    chk("busy_after", 64'(busy), 64'(0));
    chk("tready_after", 64'(s_frq_tready), 64'(1));
  endtask

  initial begin
    logic [31:0] f2;
    aresetn      = 1'b0;
    s_frq_tvalid = 1'b0;
    s_frq_tdata  = '0;
    m_tready     = '0;
    @(negedge aclk);
    @(negedge aclk);
    chk("rst_tready", 64'(s_frq_tready), 64'(0));
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tdata", m_tdata, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(cfg_done), 64'(0));
    aresetn = 1'b1;
    #1 chk("rel_tready", 64'(s_frq_tready), 64'(0));
    @(negedge aclk);
    chk("rel_tready_rise", 64'(s_frq_tready), 64'(1));

    run_cfg(32'd100000000, -1, 0, -1, 0, '0);
    run_cfg(32'd200000000, -1, 0, -1, 0, '0);
    run_cfg(32'd0, -1, 0, -1, 0, '0);
    run_cfg(32'd1600000000, -1, 0, -1, 0, '0);
    run_cfg(32'd100000000, 3, 5, -1, 0, '0);

    f2 = $urandom;
    run_cfg(32'd300000000, -1, 0, -1, 1, f2);
    run_cfg(f2, int'($urandom_range(0, LANES - 1)), int'($urandom_range(1, 4)), -1, 0, '0);

    for (int k = 0; k < 4; k++)
      run_cfg($urandom, int'($urandom_range(0, LANES - 1)), int'($urandom_range(0, 6)), -1, 0, '0);

    run_cfg(32'd100000000, -1, 0, 5, 0, '0);
    #2 aresetn = 1'b0;
    #1;
    chk("abort_tvalid", 64'(m_tvalid), 64'(0));
    chk("abort_done", 64'(cfg_done), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_tready", 64'(s_frq_tready), 64'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("abort_no_done", 64'(cfg_done), 64'(0));
      chk("abort_tvalid_hold", 64'(m_tvalid), 64'(0));
    end
    aresetn = 1'b1;
    @(negedge aclk);
    chk("abort_tready_rise", 64'(s_frq_tready), 64'(1));
    chk("abort_no_done_rel", 64'(cfg_done), 64'(0));
    run_cfg(32'd100000000, -1, 0, -1, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
